// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle and runs loads/stores
// over a req/ready data-memory handshake with a bounded wait and a sticky bus-error flag.
module memory_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] alu_data_i,
    input  logic [3:0]  rd_addr_i,
    input  logic        do_write_i,
    input  logic [31:0] rd_data_i,
    input  logic        valid_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] wb_data_o,
    output logic [3:0]  wb_addr_o,
    output logic        wb_en_o,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic        stall_o,
    output logic        bus_err_o
);

    localparam int unsigned CW = 4;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           accept_mem, accept_alu, complete, abort, stall_raw;
    logic           is_mem, is_load, is_byte;
    logic           ld_q, byte_q;
    logic [1:0]     off_q;
    logic [3:0]     rd_q;
    logic [31:0]    inst_q;
    logic [31:0]    load_data;

    assign is_mem  = (inst_i[27:25] == 3'b010);
    assign is_load = inst_i[20];
    assign is_byte = inst_i[22];

    // Reset must hold stall low even though IDLE decode still sees the input slot.
    assign stall_o = stall_raw & ~reset_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and per-cycle event strobes; flush and mem_ready only matter in their own state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_mem = 1'b0;
        accept_alu = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        stall_raw  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && !flush_i) begin
                    if (is_mem) begin
                        accept_mem = 1'b1;
                        stall_raw  = 1'b1;
                        state_d    = S_WAIT;
                        cnt_d      = '0;
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready_i) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else if (({1'b0, cnt_q} + 5'd1) == 5'(TIMEOUT)) begin
                    abort     = 1'b1;
                    stall_raw = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte-lane select for load returns, zero-extended.
    always_comb begin
        load_data = mem_rdata_i;
        if (byte_q) begin
            case (off_q)
                2'd0:    load_data = {24'd0, mem_rdata_i[7:0]};
                2'd1:    load_data = {24'd0, mem_rdata_i[15:8]};
                2'd2:    load_data = {24'd0, mem_rdata_i[23:16]};
                default: load_data = {24'd0, mem_rdata_i[31:24]};
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            wb_data_o   <= '0;
            wb_addr_o   <= '0;
            wb_en_o     <= 1'b0;
            valid_o     <= 1'b0;
            inst_o      <= '0;
            bus_err_o   <= 1'b0;
            ld_q        <= 1'b0;
            byte_q      <= 1'b0;
            off_q       <= '0;
            rd_q        <= '0;
            inst_q      <= '0;
        end else begin
            valid_o <= 1'b0;
            wb_en_o <= 1'b0;

            if (accept_alu) begin
                wb_data_o <= alu_data_i;
                wb_addr_o <= rd_addr_i;
                wb_en_o   <= do_write_i;
                valid_o   <= 1'b1;
                inst_o    <= inst_i;
            end

            if (accept_mem) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= ~is_load;
                mem_addr_o  <= {alu_data_i[31:2], 2'b00};
                mem_be_o    <= is_byte ? (4'b0001 << alu_data_i[1:0]) : 4'b1111;
                mem_wdata_o <= is_byte ? {4{rd_data_i[7:0]}} : rd_data_i;
                ld_q        <= is_load;
                byte_q      <= is_byte;
                off_q       <= alu_data_i[1:0];
                rd_q        <= rd_addr_i;
                inst_q      <= inst_i;
            end

            if (complete || abort) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
                mem_be_o  <= '0;
            end

            if (complete) begin
                valid_o   <= 1'b1;
                inst_o    <= inst_q;
                wb_addr_o <= rd_q;
                wb_en_o   <= ld_q;
                if (ld_q) begin
                    wb_data_o <= load_data;
                end
            end

            if (abort) begin
                bus_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed ops push expected writebacks, a negedge
// monitor pops and compares whenever valid_o is presented.
module tb_memory_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] inst_i, alu_data_i, rd_data_i, mem_rdata_i;
    logic [3:0]  rd_addr_i;
    logic        do_write_i, valid_i, flush_i, mem_ready_i;
    logic        mem_req_o, mem_we_o, wb_en_o, valid_o, stall_o, bus_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o, inst_o;
    logic [3:0]  mem_be_o, wb_addr_o;

    localparam logic [31:0] I_ADD  = 32'hE0912003;
    localparam logic [31:0] I_LDR  = 32'hE5912000;
    localparam logic [31:0] I_LDRB = 32'hE5D12000;
    localparam logic [31:0] I_STR  = 32'hE5812000;
    localparam logic [31:0] I_STRB = 32'hE5C12000;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  addr;
        logic        en;
        logic [31:0] inst;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    memory_stage #(.TIMEOUT(15)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .inst_i(inst_i), .alu_data_i(alu_data_i),
        .rd_addr_i(rd_addr_i), .do_write_i(do_write_i), .rd_data_i(rd_data_i),
        .valid_i(valid_i), .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .wb_data_o(wb_data_o),
        .wb_addr_o(wb_addr_o), .wb_en_o(wb_en_o), .valid_o(valid_o), .inst_o(inst_o),
        .stall_o(stall_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] a, input logic en,
                        input logic [31:0] ins, input logic cd);
        wb_exp_t e;
        e.data = d; e.addr = a; e.en = en; e.inst = ins; e.chk_data = cd;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic [3:0] rd,
                         input logic dw, input logic [31:0] sd);
        inst_i = ins; alu_data_i = alu; rd_addr_i = rd; do_write_i = dw; rd_data_i = sd;
        valid_i = 1'b1; flush_i = 1'b0;
    endtask

    // One memory op: `waits` not-ready WAIT cycles, then a ready cycle.
    task automatic run_mem(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [3:0] rd, input int waits, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic exp_we, input logic [31:0] exp_wb, input logic flush_pulse);
        issue(ins, addr, rd, 1'b0, sd);
        mid();
        chk("accept_stall", stall_o, 1);
        chk("accept_no_req", mem_req_o, 0);
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < waits; i++) begin
            mem_ready_i = 1'b0;
            if (flush_pulse && i == 1) begin
                flush_i = 1'b1; valid_i = 1'b1; inst_i = I_ADD;
            end
            mid();
            chk("wait_req", mem_req_o, 1);
            chk("wait_stall", stall_o, 1);
            chk("wait_valid", valid_o, 0);
            tick();
            flush_i = 1'b0; valid_i = 1'b0;
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = rdata;
        push(exp_wb, rd, exp_we ? 1'b0 : 1'b1, ins, !exp_we);
        mid();
        chk("mem_req", mem_req_o, 1);
        chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, exp_be});
        chk("mem_we", mem_we_o, exp_we);
        if (exp_we) chk("mem_wdata", mem_wdata_o, exp_wdata);
        chk("ready_stall", stall_o, 0);
        tick();
        mem_ready_i = 1'b0;
        mid();
        chk("done_req", mem_req_o, 0);
        chk("done_stall", stall_o, 0);
    endtask

    // Monitor: every presented writeback must match the oldest expected one.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid_o=1 inst %h expected no writeback", inst_o);
                end else begin
                    wb_exp_t e;
                    e = sb.pop_front();
                    chk("wb_en", wb_en_o, e.en);
                    chk("inst_o", inst_o, e.inst);
                    if (e.chk_data) begin
                        chk("wb_data", wb_data_o, e.data);
                        chk("wb_addr", wb_addr_o, e.addr);
                    end
                end
            end else begin
                chk("bubble_wb_en", wb_en_o, 0);
            end
        end
    end

    initial begin
        reset_i = 1'b1; mem_ready_i = 1'b0; mem_rdata_i = '0; flush_i = 1'b0;
        issue(I_LDR, 32'h0, 4'd1, 1'b1, 32'h0);
        tick(); tick(); mid();
        chk("rst_req", mem_req_o, 0);   chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0); chk("rst_be", mem_be_o, 0);
        chk("rst_wdata", mem_wdata_o, 0); chk("rst_wbdata", wb_data_o, 0);
        chk("rst_wbaddr", wb_addr_o, 0); chk("rst_wben", wb_en_o, 0);
        chk("rst_valid", valid_o, 0);   chk("rst_inst", inst_o, 0);
        chk("rst_stall", stall_o, 0);   chk("rst_buserr", bus_err_o, 0);
        tick();
        reset_i = 1'b0; valid_i = 1'b0;
        tick();

        // ADD passthrough
        issue(I_ADD, 32'h5, 4'd2, 1'b1, 32'h0);
        push(32'h5, 4'd2, 1'b1, I_ADD, 1'b1);
        mid(); chk("add_stall", stall_o, 0);
        tick(); valid_i = 1'b0;
        mid(); chk("add_stall2", stall_o, 0);
        tick();

        // word load, byte store, byte load
        run_mem(I_LDR, 32'h103, 32'h0, 4'd3, 0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
        tick();
        run_mem(I_STRB, 32'h202, 32'h123456AB, 4'd4, 0, 32'h0, 4'b0100, 32'hABABABAB, 1'b1, 32'h0, 1'b0);
        tick();
        run_mem(I_LDRB, 32'h201, 32'h0, 4'd7, 0, 32'h11223344, 4'b0010, 32'h0, 1'b0, 32'h00000033, 1'b0);
        tick();

        // three wait states with a flush pulse inside WAIT
        run_mem(I_LDR, 32'h40C, 32'h0, 4'd5, 3, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 32'h0BADF00D, 1'b1);
        tick();

        // flushed slot in IDLE
        issue(I_LDR, 32'h480, 4'd6, 1'b1, 32'h0);
        flush_i = 1'b1;
        mid(); chk("flush_stall", stall_o, 0);
        tick(); valid_i = 1'b0; flush_i = 1'b0;
        mid(); chk("flush_req", mem_req_o, 0); chk("flush_valid", valid_o, 0);
        tick();

        // ready arrives in the last allowed WAIT cycle: completion, no error
        run_mem(I_LDRB, 32'h503, 32'h0, 4'd8, 14, 32'hA1B2C3D4, 4'b1000, 32'h0, 1'b0, 32'h000000A1, 1'b0);
        chk("coincide_buserr", bus_err_o, 0);
        tick();

        // timeout
        issue(I_LDR, 32'h500, 4'd6, 1'b0, 32'h0);
        tick(); valid_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            mid();
            chk("to_req", mem_req_o, 1);
            chk("to_buserr_low", bus_err_o, 0);
            tick();
        end
        mid();
        chk("to_req_drop", mem_req_o, 0); chk("to_stall", stall_o, 0);
        chk("to_buserr", bus_err_o, 1);   chk("to_valid", valid_o, 0);
        chk("to_wben", wb_en_o, 0);
        tick();

        // bus_err stays set through later ops
        issue(I_ADD, 32'h77, 4'd9, 1'b1, 32'h0);
        push(32'h77, 4'd9, 1'b1, I_ADD, 1'b1);
        tick(); valid_i = 1'b0;
        mid(); chk("sticky_buserr1", bus_err_o, 1);
        tick();
        run_mem(I_STR, 32'h304, 32'hDEADBEEF, 4'd1, 1, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        chk("sticky_buserr2", bus_err_o, 1);
        tick();

        // async reset mid-WAIT
        issue(I_STR, 32'h600, 4'd2, 1'b0, 32'h55);
        tick(); valid_i = 1'b0;
        mid(); chk("rw_req", mem_req_o, 1); chk("rw_we", mem_we_o, 1);
        @(posedge clk_i); #2;
        reset_i = 1'b1;
        #1;
        chk("ar_req", mem_req_o, 0);   chk("ar_stall", stall_o, 0);
        chk("ar_valid", valid_o, 0);   chk("ar_we", mem_we_o, 0);
        chk("ar_buserr", bus_err_o, 0);
        tick(); tick();
        reset_i = 1'b0;
        tick();
        mid(); chk("post_rst_req", mem_req_o, 0);
        tick();
        mid();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles without mem_ready_i before a request is aborted.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_i  in  32 (instruction from execute); alu_data_i  in  32 (ALU result / effective address); rd_addr_i  in  4 (destination register); do_write_i  in  1 (execute requests register writeback).
REQ-005 SHALL have ports rd_data_i  in  32 (store data); valid_i  in  1 (input slot valid); flush_i  in  1 (squash the input slot).
REQ-006 SHALL have ports mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_be_o  out  4; mem_wdata_o  out  32; mem_rdata_i  in  32; mem_ready_i  in  1 (data-memory handshake).
REQ-007 SHALL have ports wb_data_o  out  32; wb_addr_o  out  4; wb_en_o  out  1; valid_o  out  1; inst_o  out  32 (registered writeback-stage slot).
REQ-008 SHALL have ports stall_o  out  1 (hold upstream) and bus_err_o  out  1 (sticky timeout flag).

Function
REQ-009 SHALL decode a memory op as inst_i[27:25]==3'b010; L = inst_i[20] (1 = load, 0 = store); B = inst_i[22] (1 = byte, 0 = word).
REQ-010 SHALL accept the input slot when valid_i=1 and flush_i=0 in state IDLE; otherwise the slot is a bubble (valid_o <= 0, wb_en_o <= 0).
REQ-011 SHALL pass an accepted non-memory op through in 1 cycle: wb_data_o <= alu_data_i, wb_addr_o <= rd_addr_i, wb_en_o <= do_write_i, valid_o <= 1, inst_o <= inst_i.
REQ-012 SHALL implement FSM states IDLE and WAIT; an accepted memory op moves IDLE->WAIT and latches the address, data, byte enables, L, B, rd_addr_i and inst_i.
REQ-013 SHALL assert mem_req_o only in WAIT, with mem_addr_o = {addr[31:2],2'b00} and mem_we_o = ~L, all held stable until mem_ready_i.
REQ-014 SHALL drive mem_be_o = 4'b1111 for a word access and one-hot 1<<addr[1:0] for a byte access.
REQ-015 SHALL drive mem_wdata_o = store data for a word store and the low byte replicated four times for a byte store.
REQ-016 SHALL complete on WAIT & mem_ready_i, returning to IDLE on the next edge.
REQ-017 On a load completion, SHALL set wb_data_o to mem_rdata_i (word) or to the byte selected by addr[1:0], zero-extended (byte), with wb_en_o=1 and valid_o=1.
REQ-018 On a store completion, SHALL set valid_o=1 and wb_en_o=0.
REQ-019 SHALL drive stall_o = (IDLE & accepted memory op) | (WAIT & ~mem_ready_i), combinationally; minimum memory-op latency is 2 cycles.
REQ-020 SHALL drive valid_o=0 and wb_en_o=0 in every cycle spent in WAIT without completion.
REQ-021 SHALL ignore flush_i while in WAIT, because the in-flight op is older than the flushing branch and completes normally.
REQ-022 SHALL keep a 4-bit WAIT-cycle counter, cleared on entry to WAIT.
REQ-023 When the counter reaches TIMEOUT without mem_ready_i, SHALL abort the op: return to IDLE, valid_o=0, wb_en_o=0, bus_err_o <= 1.
REQ-024 SHALL clear bus_err_o only on reset.
REQ-025 If mem_ready_i and timeout coincide, SHALL treat the cycle as a completion, with no error.
REQ-026 SHALL ignore mem_ready_i while in IDLE.

Reset
REQ-027 While reset_i=1, SHALL force state to IDLE, the counter to 0, and mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, wb_data_o, wb_addr_o, wb_en_o, valid_o, inst_o, stall_o and bus_err_o to 0, asynchronously.
REQ-028 SHALL issue no memory write on an op interrupted by reset mid-WAIT, and SHALL produce no writeback from it.

Verification
REQ-029 Bench SHALL cover ADD passthrough: valid_i=1, inst_i=0xE0912003, alu_data_i=0x5, rd_addr_i=2, do_write_i=1 -> after 1 edge wb_data_o=0x5, wb_addr_o=2, wb_en_o=1, valid_o=1, stall_o=0 throughout.
REQ-030 Bench SHALL cover word load: LDR with alu_data_i=0x103, mem_ready_i=1 on the first WAIT cycle -> mem_addr_o=0x100, mem_be_o=4'hF, mem_we_o=0; mem_rdata_i=0xCAFEF00D -> wb_data_o=0xCAFEF00D, wb_en_o=1; stall_o high exactly 1 cycle.
REQ-031 Bench SHALL cover byte load/store: STRB at 0x202 with rd_data_i=0x123456AB -> mem_be_o=4'b0100, mem_wdata_o=0xABABABAB, mem_we_o=1, wb_en_o=0; then LDRB at 0x201 with mem_rdata_i=0x11223344 -> wb_data_o=0x00000033.
REQ-032 Bench SHALL cover wait states plus flush: mem_ready_i held low 3 cycles with flush_i pulsed in WAIT -> mem_req_o/stall_o high for 3 cycles, op completes on cycle 4 with valid_o=1; flush_i=1 with valid_i=1 in IDLE -> no mem_req_o, valid_o=0.
REQ-033 Bench SHALL cover timeout: mem_ready_i never asserted -> after 15 WAIT cycles state returns to IDLE, bus_err_o=1, wb_en_o=0, bus_err_o remains 1 through later ops until reset_i.
REQ-034 Bench SHALL cover async reset: reset_i asserted mid-WAIT between clock edges -> mem_req_o, stall_o and valid_o drop to 0 immediately, and no write is seen on the memory port.
